// File: rtl/data_mem_if.sv
// Load/store-unit to data memory controller bus.
// Master (LSU) drives address, store data, byte strobes and the read strobe;
// slave (controller) returns read data plus busy, valid, fault and error status.
interface data_mem_if;
  // request side
  logic [31:0] mem_addr;    // byte address, bits [1:0] ignored by the slave
  logic [31:0] mem_wdata;   // lane-replicated store data
  logic [3:0]  mem_wstrb;   // byte write enables, any bit set = write request
  logic        mem_rstrb;   // read request strobe
  // response / status side
  logic [31:0] mem_rdata;   // read data, held until the next completed read
  logic        mem_rvalid;  // one-cycle pulse when mem_rdata updates
  logic        mem_rbusy;   // read in flight
  logic        mem_wbusy;   // write in flight
  logic        addr_fault;  // one-cycle pulse after accepting an out-of-range request
  logic        proto_err;   // sticky protocol error

  modport master (
    output mem_addr, mem_wdata, mem_wstrb, mem_rstrb,
    input  mem_rdata, mem_rvalid, mem_rbusy, mem_wbusy, addr_fault, proto_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wstrb, mem_rstrb,
    output mem_rdata, mem_rvalid, mem_rbusy, mem_wbusy, addr_fault, proto_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte-enable writes behind the load/store unit.
// Latency: read data READ_LAT cycles after acceptance; write commits WRITE_LAT-1 edges after acceptance.
// Backpressure: mem_rbusy/mem_wbusy block new requests; strobes while busy are dropped and flagged.
// Ports: clk, reset (sync, active-high), bus (data_mem_if.slave: request in, rdata/status out).
module data_mem_ctrl #(
  parameter int MEM_WORDS = 1024,  // power of two, >= 16
  parameter int READ_LAT  = 1,     // 1..15
  parameter int WRITE_LAT = 1      // 1..15
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Single-cycle ops finish on the accepting edge and never leave IDLE.
  localparam bit         RD_IMM  = (READ_LAT == 1);
  localparam bit         WR_IMM  = (WRITE_LAT == 1);
  // cnt value during the last busy cycle; the op finishes on the edge ending it.
  localparam logic [3:0] RD_LAST = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_LAT - 1);

  logic [31:0]   ram [MEM_WORDS];

  logic [1:0]    state;
  logic [3:0]    cnt;       // cycles elapsed since acceptance, saturates at *_LAST
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          oor_q;

  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          rbusy_q;
  logic          wbusy_q;
  logic          fault_q;
  logic          proto_q;

  // request decode
  logic          idle;
  logic          wr_req;
  logic          rd_req;
  logic          acc_wr;
  logic          acc_rd;
  logic          req_oor;
  logic [AW-1:0] req_idx;
  logic          proto_hit;

  // completion paths
  logic          rd_fin;
  logic [AW-1:0] rd_idx;
  logic          rd_oor;
  logic          wr_go;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_dat;
  logic [3:0]    wr_stb;

  // Lane steering is done upstream; the byte offset carries no information here.
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^bus.mem_addr[1:0];

  assign idle    = (state == ST_IDLE);
  assign wr_req  = |bus.mem_wstrb;
  assign rd_req  = bus.mem_rstrb;
  // A write strobe wins over a coincident read strobe.
  assign acc_wr  = idle & wr_req;
  assign acc_rd  = idle & rd_req & ~wr_req;
  assign req_idx = bus.mem_addr[AW+1:2];
  // Range check on the full word address, so aliasing high bits still fault.
  assign req_oor = |(bus.mem_addr[31:2] >> AW);

  assign proto_hit = (~idle & (rd_req | wr_req)) | (idle & rd_req & wr_req);

  // Read completion: immediate for single-cycle reads, else on the last busy cycle.
  always_comb begin
    rd_fin = 1'b0;
    rd_idx = idx_q;
    rd_oor = oor_q;
    if (idle) begin
      rd_fin = acc_rd & RD_IMM;
      rd_idx = req_idx;
      rd_oor = req_oor;
    end else if (state == ST_READ) begin
      rd_fin = (cnt == RD_LAST);
    end
  end

  // Write commit: same structure; out-of-range writes run the timing but never commit.
  always_comb begin
    wr_go  = 1'b0;
    wr_idx = idx_q;
    wr_dat = wdata_q;
    wr_stb = wstrb_q;
    if (idle) begin
      wr_go  = acc_wr & WR_IMM & ~req_oor;
      wr_idx = req_idx;
      wr_dat = bus.mem_wdata;
      wr_stb = bus.mem_wstrb;
    end else if (state == ST_WRITE) begin
      wr_go  = (cnt == WR_LAST) & ~oor_q;
    end
    // A reset on the commit edge drops the write.
    wr_go = wr_go & ~reset;
  end

  // Storage has no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_stb[i]) begin
          ram[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      oor_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rbusy_q  <= 1'b0;
      wbusy_q  <= 1'b0;
      fault_q  <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;

      if (proto_hit) begin
        proto_q <= 1'b1;
      end

      if (rd_fin) begin
        rdata_q  <= rd_oor ? 32'd0 : ram[rd_idx];
        rvalid_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (acc_wr | acc_rd) begin
            idx_q   <= req_idx;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            oor_q   <= req_oor;
            fault_q <= req_oor;
            if (acc_wr && !WR_IMM) begin
              state   <= ST_WRITE;
              cnt     <= 4'd1;
              wbusy_q <= 1'b1;
            end else if (acc_rd && !RD_IMM) begin
              state   <= ST_READ;
              cnt     <= 4'd1;
              rbusy_q <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (cnt == RD_LAST) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rbusy_q <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_WRITE: begin
          if (cnt == WR_LAST) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wbusy_q <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          cnt     <= 4'd0;
          rbusy_q <= 1'b0;
          wbusy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.mem_rbusy  = rbusy_q;
  assign bus.mem_wbusy  = wbusy_q;
  assign bus.addr_fault = fault_q;
  assign bus.proto_err  = proto_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a single-cycle instance driven from a vector table,
// and a READ_LAT=3 / WRITE_LAT=4 instance driven by hand-written sequences.
// Status vectors are packed as {rvalid, rbusy, wbusy, addr_fault, proto_err}.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_if ifa();
  data_mem_if ifb();

  data_mem_ctrl #(.MEM_WORDS(1024), .READ_LAT(1), .WRITE_LAT(1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  data_mem_ctrl #(.MEM_WORDS(1024), .READ_LAT(3), .WRITE_LAT(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  typedef struct {
    logic        rst;
    logic        rd;
    logic [3:0]  ws;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] e_rdata;
    logic [4:0]  e_stat;
  } vec_t;

  localparam int NV = 19;
  vec_t va [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_a();
    return {27'd0, ifa.mem_rvalid, ifa.mem_rbusy, ifa.mem_wbusy, ifa.addr_fault, ifa.proto_err};
  endfunction

  function automatic logic [31:0] stat_b();
    return {27'd0, ifb.mem_rvalid, ifb.mem_rbusy, ifb.mem_wbusy, ifb.addr_fault, ifb.proto_err};
  endfunction

  // Drive one cycle of B inputs, then sample just after the edge that ends it.
  task automatic cyc_b(input logic r, input logic rd, input logic [3:0] ws,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_b          = r;
    ifb.mem_rstrb  = rd;
    ifb.mem_wstrb  = ws;
    ifb.mem_addr   = a;
    ifb.mem_wdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic [31:0] e_rdata, input logic [4:0] e_stat);
    check({name, " rdata"}, ifb.mem_rdata, e_rdata);
    check({name, " stat"}, stat_b(), {27'd0, e_stat});
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.mem_rstrb = 1'b0; ifa.mem_wstrb = 4'd0; ifa.mem_addr = 32'd0; ifa.mem_wdata = 32'd0;
    ifb.mem_rstrb = 1'b0; ifb.mem_wstrb = 4'd0; ifb.mem_addr = 32'd0; ifb.mem_wdata = 32'd0;

    //        rst  rd    ws     addr          wdata          exp rdata      exp stat
    va[0]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0,         5'b00000};
    va[1]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0,         5'b00000};
    va[2]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0000, 32'h0102_0304, 32'h0,         5'b00000};
    va[3]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         5'b00000};
    va[4]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 5'b10000};
    va[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 5'b00000};
    va[6]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 5'b00000};
    va[7]  = '{1'b0, 1'b0, 4'h4, 32'h0000_0012, 32'h00AA_0000, 32'hDEAD_BEEF, 5'b00000};
    va[8]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11AA_3344, 5'b10000};
    va[9]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0013, 32'h0,         32'h11AA_3344, 5'b10000};
    va[10] = '{1'b0, 1'b1, 4'h0, 32'h0000_1000, 32'h0,         32'h0,         5'b10010};
    va[11] = '{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,         5'b00010};
    va[12] = '{1'b0, 1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'h0102_0304, 5'b10000};
    va[13] = '{1'b0, 1'b1, 4'h0, 32'h8000_0010, 32'h0,         32'h0,         5'b10010};
    va[14] = '{1'b0, 1'b1, 4'h3, 32'h0000_0010, 32'h5555_BEEF, 32'h0,         5'b00001};
    va[15] = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11AA_BEEF, 5'b10001};
    va[16] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h11AA_BEEF, 5'b00001};
    va[17] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0,         5'b00000};
    va[18] = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11AA_BEEF, 5'b10000};

    // Single-cycle instance: every output is a function of the previous cycle's inputs.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_a         = va[i].rst;
      ifa.mem_rstrb = va[i].rd;
      ifa.mem_wstrb = va[i].ws;
      ifa.mem_addr  = va[i].addr;
      ifa.mem_wdata = va[i].wd;
      @(posedge clk);
      #1;
      check($sformatf("A%0d rdata", i), ifa.mem_rdata, va[i].e_rdata);
      check($sformatf("A%0d stat", i), stat_a(), {27'd0, va[i].e_stat});
    end
    @(negedge clk);
    ifa.mem_rstrb = 1'b0;

    // Multi-cycle instance: write with WRITE_LAT=4, then read back with READ_LAT=3.
    cyc_b(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B reset", 32'h0, 5'b00000);
    cyc_b(1'b0, 1'b0, 4'hF, 32'h20, 32'hAABB_CCDD);   chk_b("B wr T+1", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B wr T+2", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B wr T+3", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B wr T+4", 32'h0, 5'b00000);
    // Read accepted in T+4 must already see the write.
    cyc_b(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);           chk_b("B rd R+1", 32'h0, 5'b01000);
    // Stray strobe while busy: ignored, error flag rises.
    cyc_b(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);            chk_b("B rd R+2", 32'h0, 5'b01001);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B rd R+3", 32'hAABB_CCDD, 5'b10001);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B rd R+4", 32'hAABB_CCDD, 5'b00001);

    // Reset two cycles into a WRITE_LAT=4 write aborts it before commit.
    cyc_b(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B reset2", 32'h0, 5'b00000);
    cyc_b(1'b0, 1'b0, 4'hF, 32'h20, 32'h1234_5678);   chk_b("B abt T+1", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B abt T+2", 32'h0, 5'b00100);
    cyc_b(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B abt T+3", 32'h0, 5'b00000);
    cyc_b(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);           chk_b("B chk R+1", 32'h0, 5'b01000);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B chk R+2", 32'h0, 5'b01000);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B chk R+3", 32'hAABB_CCDD, 5'b10000);

    // Out-of-range read and write keep normal busy timing; fault pulses once.
    cyc_b(1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);         chk_b("B oor rd+1", 32'hAABB_CCDD, 5'b01010);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B oor rd+2", 32'hAABB_CCDD, 5'b01000);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B oor rd+3", 32'h0, 5'b10000);
    cyc_b(1'b0, 1'b0, 4'hF, 32'h1000, 32'hFFFF_FFFF); chk_b("B oor wr+1", 32'h0, 5'b00110);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B oor wr+2", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B oor wr+3", 32'h0, 5'b00100);
    cyc_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);            chk_b("B oor wr+4", 32'h0, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
